// File: rtl/i2c_reg_slave_pkg.sv
// Shared types and constants for the I2C register target and its line filter.
package i2c_reg_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RFETCH,
    RDATA,
    RACK,
    IGNORE
  } state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam int   RW_BIT   = 0;
  localparam int   FILTER_CYCLES_DEFAULT = 3;

endpackage

// File: rtl/i2c_reg_slave_line_filter.sv
// Synchronizes and deglitches SCL/SDA, then derives bus edges and START/STOP
// from the filtered levels only.
module i2c_line_filter
  import i2c_reg_pkg::*;
#(
  parameter int FILTER_CYCLES = FILTER_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic resetn,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);

  // Bit 0 carries SCL, bit 1 carries SDA; both idle high.
  logic [1:0]    sync1, sync2, filt, filt_d;
  logic [CW-1:0] cnt [2];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync1  <= '1;
      sync2  <= '1;
      filt   <= '1;
      filt_d <= '1;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1  <= {sda_in, scl_in};
      sync2  <= sync1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(FILTER_CYCLES - 1)) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign sda      = filt[1];
  assign scl_rise = filt[0] & ~filt_d[0];
  assign scl_fall = ~filt[0] & filt_d[0];
  assign start    = filt[0] & filt_d[0] & filt_d[1] & ~filt[1];
  assign stop     = filt[0] & filt_d[0] & ~filt_d[1] & filt[1];

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C target translating bus writes/reads into single-byte register requests,
// with an auto-incrementing register pointer and no clock stretching.
module i2c_reg_slave
  import i2c_reg_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDRESS    = 7'h48,
  parameter int         REG_ADDRESS_WIDTH = 2,
  parameter int         FILTER_CYCLES     = FILTER_CYCLES_DEFAULT
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         scl_in,
  input  logic                         sda_in,
  output logic                         sda_oe,
  output logic [REG_ADDRESS_WIDTH-1:0] reg_address,
  output logic                         reg_is_write,
  output logic                         reg_request,
  input  logic                         reg_response,
  input  logic [7:0]                   reg_read_data,
  output logic [7:0]                   reg_write_data,
  output state_t                       debug_state,
  output logic [REG_ADDRESS_WIDTH-1:0] debug_pointer
);

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter (
    .clock    (clock),
    .resetn   (resetn),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  state_t                       state;
  logic [3:0]                   bit_cnt;
  logic [7:0]                   shift;
  logic [REG_ADDRESS_WIDTH-1:0] pointer;
  logic                         req_wait, req_write_q, outstanding;
  logic [REG_ADDRESS_WIDTH-1:0] req_addr_q;
  logic [7:0]                   req_data_q;
  logic                         rd_valid;
  logic [7:0]                   rd_buf;

  logic [7:0]                   rx_byte;
  logic [7:0]                   fetch_byte;
  logic [REG_ADDRESS_WIDTH-1:0] ptr_inc;

  assign rx_byte = {shift[6:0], sda};
  assign ptr_inc = pointer + 1'b1;
  // A response landing on the very fall that starts the byte is still used.
  assign fetch_byte = (reg_response && !reg_is_write) ? reg_read_data :
                      rd_valid                        ? rd_buf        : 8'hFF;

  assign debug_state   = state;
  assign debug_pointer = pointer;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      shift          <= '0;
      pointer        <= '0;
      sda_oe         <= 1'b0;
      reg_request    <= 1'b0;
      reg_is_write   <= 1'b0;
      reg_address    <= '0;
      reg_write_data <= '0;
      req_wait       <= 1'b0;
      req_write_q    <= 1'b0;
      req_addr_q     <= '0;
      req_data_q     <= '0;
      outstanding    <= 1'b0;
      rd_valid       <= 1'b0;
      rd_buf         <= '0;
    end else begin
      reg_request <= 1'b0;

      if (reg_response) begin
        outstanding <= 1'b0;
        if (!reg_is_write) begin
          rd_buf   <= reg_read_data;
          rd_valid <= 1'b1;
        end
      end

      // Staged requests launch only once the previous one has completed.
      if (req_wait && !outstanding) begin
        reg_request  <= 1'b1;
        reg_is_write <= req_write_q;
        reg_address  <= req_addr_q;
        if (req_write_q) reg_write_data <= req_data_q;
        outstanding  <= 1'b1;
        req_wait     <= 1'b0;
      end

      if (stop) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
      end else if (start) begin
        state   <= ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WDATA: begin
            if (scl_rise) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                case (state)
                  ADDR: state <= (rx_byte[7:1] == DEVICE_ADDRESS) ? ADDR_ACK : IGNORE;
                  PTR: begin
                    pointer <= rx_byte[REG_ADDRESS_WIDTH-1:0];
                    state   <= PTR_ACK;
                  end
                  default: begin
                    req_wait    <= 1'b1;
                    req_write_q <= 1'b1;
                    req_addr_q  <= pointer;
                    req_data_q  <= rx_byte;
                    pointer     <= ptr_inc;
                    state       <= WDATA_ACK;
                  end
                endcase
              end
            end
          end
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            // sda_oe doubles as the phase flag: first fall asserts, second ends the ACK.
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                state  <= (state == ADDR_ACK) ? PTR : WDATA;
              end
            end else if (scl_rise && state == ADDR_ACK && shift[RW_BIT]) begin
              state       <= RFETCH;
              req_wait    <= 1'b1;
              req_write_q <= 1'b0;
              req_addr_q  <= pointer;
              rd_valid    <= 1'b0;
            end
          end
          RFETCH: begin
            if (scl_fall) begin
              sda_oe   <= ~fetch_byte[7];
              shift    <= {fetch_byte[6:0], 1'b0};
              bit_cnt  <= 4'd1;
              rd_valid <= 1'b0;
              state    <= RDATA;
            end
          end
          RDATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= RACK;
              end else begin
                sda_oe  <= ~shift[7];
                shift   <= {shift[6:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          RACK: begin
            if (scl_rise) begin
              if (sda == I2C_ACK) begin
                pointer     <= ptr_inc;
                state       <= RFETCH;
                req_wait    <= 1'b1;
                req_write_q <= 1'b0;
                req_addr_q  <= ptr_inc;
                rd_valid    <= 1'b0;
              end else begin
                state <= IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench: bit-banged I2C host, 1-cycle register responder and a
// scoreboard of expected register requests.
module tb_i2c_reg_slave;
  import i2c_reg_pkg::*;

  localparam int Q = 12;

  logic       clock = 1'b0;
  logic       resetn;
  logic       scl_drv, sda_drv;
  logic       sda_line;
  logic       sda_oe;
  logic [1:0] reg_address;
  logic       reg_is_write, reg_request;
  logic       reg_response = 1'b0;
  logic [7:0] reg_read_data = 8'h00;
  logic [7:0] reg_write_data;
  state_t     debug_state;
  logic [1:0] debug_pointer;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];
  logic [7:0]  rd_q[$];
  logic        sda_low_seen = 1'b0;

  assign sda_line = sda_drv & ~sda_oe;

  i2c_reg_slave dut (
    .clock          (clock),
    .resetn         (resetn),
    .scl_in         (scl_drv),
    .sda_in         (sda_line),
    .sda_oe         (sda_oe),
    .reg_address    (reg_address),
    .reg_is_write   (reg_is_write),
    .reg_request    (reg_request),
    .reg_response   (reg_response),
    .reg_read_data  (reg_read_data),
    .reg_write_data (reg_write_data),
    .debug_state    (debug_state),
    .debug_pointer  (debug_pointer)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register responder and request scoreboard.
  always @(negedge clock) begin
    logic [10:0] observed;
    if (resetn && sda_oe) sda_low_seen = 1'b1;
    reg_response = 1'b0;
    if (reg_request) begin
      observed = {reg_is_write, reg_address, reg_is_write ? reg_write_data : 8'h00};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_request: observed=%0h expected=none", observed);
      end else begin
        check("request", 32'(observed), 32'(exp_q.pop_front()));
      end
      reg_read_data = (rd_q.size() != 0) ? rd_q.pop_front() : 8'h00;
      reg_response  = 1'b1;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bus_start();
    sda_drv = 1'b1; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    sda_drv = 1'b0; wait_clk(Q);
    scl_drv = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    sda_drv = 1'b1; wait_clk(Q);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    sda_drv = b;    wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    s = sda_line;   wait_clk(Q);
    scl_drv = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic host_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(host_ack, s);
  endtask

  function automatic logic [10:0] wr_req(input logic [1:0] a, input logic [7:0] d);
    return {1'b1, a, d};
  endfunction

  function automatic logic [10:0] rd_req(input logic [1:0] a);
    return {1'b0, a, 8'h00};
  endfunction

  initial begin
    logic       ack, s;
    logic [7:0] rx;

    resetn = 1'b0; scl_drv = 1'b1; sda_drv = 1'b1;
    wait_clk(4);
    check("rst_sda_oe",      32'(sda_oe), 0);
    check("rst_reg_request", 32'(reg_request), 0);
    check("rst_is_write",    32'(reg_is_write), 0);
    check("rst_reg_address", 32'(reg_address), 0);
    check("rst_write_data",  32'(reg_write_data), 0);
    check("rst_state",       32'(debug_state), 32'(IDLE));
    check("rst_pointer",     32'(debug_pointer), 0);
    resetn = 1'b1;
    wait_clk(Q);

    // Single write to register 3.
    exp_q.push_back(wr_req(2'd3, 8'h5A));
    bus_start();
    send_byte(8'h90, ack); check("w1_addr_ack", 32'(ack), 32'(I2C_ACK));
    send_byte(8'h03, ack); check("w1_ptr_ack",  32'(ack), 32'(I2C_ACK));
    send_byte(8'h5A, ack); check("w1_data_ack", 32'(ack), 32'(I2C_ACK));
    bus_stop();
    check("w1_state",   32'(debug_state), 32'(IDLE));
    check("w1_pointer", 32'(debug_pointer), 0);
    check("w1_sda_oe",  32'(sda_oe), 0);

    // Burst wrapping past the last register.
    exp_q.push_back(wr_req(2'd2, 8'h11));
    exp_q.push_back(wr_req(2'd3, 8'h22));
    exp_q.push_back(wr_req(2'd0, 8'h33));
    bus_start();
    send_byte(8'h90, ack); check("w2_addr_ack", 32'(ack), 32'(I2C_ACK));
    send_byte(8'h02, ack); check("w2_ptr_ack",  32'(ack), 32'(I2C_ACK));
    send_byte(8'h11, ack); check("w2_d0_ack",   32'(ack), 32'(I2C_ACK));
    send_byte(8'h22, ack); check("w2_d1_ack",   32'(ack), 32'(I2C_ACK));
    send_byte(8'h33, ack); check("w2_d2_ack",   32'(ack), 32'(I2C_ACK));
    bus_stop();
    check("w2_pointer", 32'(debug_pointer), 1);

    // Pointer write, repeated START, two-byte read.
    exp_q.push_back(rd_req(2'd1));
    exp_q.push_back(rd_req(2'd2));
    rd_q.push_back(8'hA5);
    rd_q.push_back(8'h3C);
    bus_start();
    send_byte(8'h90, ack); check("r_addr_ack", 32'(ack), 32'(I2C_ACK));
    send_byte(8'h01, ack); check("r_ptr_ack",  32'(ack), 32'(I2C_ACK));
    bus_start();
    send_byte(8'h91, ack); check("r_raddr_ack", 32'(ack), 32'(I2C_ACK));
    recv_byte(I2C_ACK, rx);  check("r_byte0", 32'(rx), 32'hA5);
    recv_byte(I2C_NACK, rx); check("r_byte1", 32'(rx), 32'h3C);
    check("r_released", 32'(sda_oe), 0);
    check("r_state",    32'(debug_state), 32'(IGNORE));
    bus_stop();
    check("r_pointer",  32'(debug_pointer), 2);

    // Foreign address is never acknowledged; a following START to us is.
    sda_low_seen = 1'b0;
    bus_start();
    send_byte(8'h92, ack); check("m_addr_nack", 32'(ack), 32'(I2C_NACK));
    send_byte(8'h00, ack); check("m_data_nack", 32'(ack), 32'(I2C_NACK));
    check("m_sda_never_low", 32'(sda_low_seen), 0);
    bus_start();
    send_byte(8'h90, ack); check("m_next_ack", 32'(ack), 32'(I2C_ACK));
    bus_stop();
    check("m_state", 32'(debug_state), 32'(IDLE));

    // A 2-clock SCL glitch must not shift a bit; then abort mid-byte.
    exp_q.push_back(wr_req(2'd0, 8'h5A));
    bus_start();
    send_byte(8'h90, ack); check("g_addr_ack", 32'(ack), 32'(I2C_ACK));
    send_byte(8'h00, ack); check("g_ptr_ack",  32'(ack), 32'(I2C_ACK));
    scl_drv = 1'b1; wait_clk(2);
    scl_drv = 1'b0; wait_clk(Q);
    send_byte(8'h5A, ack); check("g_data_ack", 32'(ack), 32'(I2C_ACK));
    clock_bit(1'b1, s); clock_bit(1'b0, s); clock_bit(1'b1, s); clock_bit(1'b0, s);
    bus_stop();
    check("a_state",   32'(debug_state), 32'(IDLE));
    check("a_sda_oe",  32'(sda_oe), 0);
    check("a_pointer", 32'(debug_pointer), 1);

    // Reset while the target is driving read data.
    exp_q.push_back(rd_req(2'd1));
    rd_q.push_back(8'h00);
    bus_start();
    send_byte(8'h91, ack); check("x_addr_ack", 32'(ack), 32'(I2C_ACK));
    check("x_driving", 32'(sda_oe), 1);
    resetn = 1'b0;
    @(posedge clock); #1;
    check("x_sda_oe",  32'(sda_oe), 0);
    check("x_state",   32'(debug_state), 32'(IDLE));
    check("x_pointer", 32'(debug_pointer), 0);
    @(negedge clock);
    resetn = 1'b1;
    sda_drv = 1'b1; scl_drv = 1'b1;
    wait_clk(4 * Q);

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_reg_slave.md
Name: i2c_reg_slave

Overview:
- I2C target (slave) that turns bus transactions from the M5Stack host into single-byte register requests on the LED driver's register port (reg_address/reg_is_write/reg_request/reg_response/data).
- Sits directly upstream of the WS2812B driver.
- Supports a register pointer with auto-increment for writes, and reads using repeated START.
- No clock stretching.

Parameters:
- DEVICE_ADDRESS, 7'h48, 7-bit I2C address matched in the address byte.
- REG_ADDRESS_WIDTH, 2, width of the register pointer and of reg_address.
- FILTER_CYCLES, 3, clocks a synchronized SCL/SDA level must be stable before it is accepted.

Ports:
- clock  in  1  system clock (24 MHz nominal).
- resetn  in  1  reset: synchronous, active-low.
- scl_in  in  1  raw SCL from pad.
- sda_in  in  1  raw SDA from pad.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- reg_address  out  REG_ADDRESS_WIDTH  register index for the current request.
- reg_is_write  out  1  1 = write request, 0 = read request.
- reg_request  out  1  one-cycle request strobe.
- reg_response  in  1  one-cycle completion strobe from downstream.
- reg_read_data  in  8  read data, valid in the reg_response cycle.
- reg_write_data  out  8  write data, held stable until the next request.

Behaviour:
- Input conditioning:
  - 2-FF synchronizer, then a glitch filter: the filtered level updates only after FILTER_CYCLES consecutive equal samples.
  - All edges are derived from the filtered levels: scl_rise, scl_fall, start (SDA falls while SCL is high), stop (SDA rises while SCL is high).
- Reset values: sda_oe=0, reg_request=0, reg_is_write=0, reg_address=0, reg_write_data=0. The pointer resets to 0 and the state machine to IDLE.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RFETCH, RDATA, RACK, IGNORE.
- Priority: start in any state → ADDR (bit count cleared, sda_oe=0). stop in any state → IDLE (sda_oe=0). A stop takes precedence over same-cycle bit processing.
- Bit handling:
  - Bits are sampled MSB first on scl_rise.
  - Target-driven bits (ACK, read data) change only on scl_fall.
  - sda_oe is held through the SCL high phase.
- ADDR: after 8 bits, compare the upper 7 bits with DEVICE_ADDRESS.
  - Mismatch → IGNORE (SDA released until start/stop).
  - Match → ADDR_ACK: sda_oe=1 from the next scl_fall to the following scl_fall.
  - After the ACK, R/W=0 → PTR; R/W=1 → RFETCH.
- PTR: 8th bit → pointer := byte[REG_ADDRESS_WIDTH-1:0] (upper bits ignored), ACK, then WDATA.
- WDATA: on the 8th scl_rise:
  - Pulse reg_request with reg_is_write=1, reg_address=pointer, reg_write_data=byte.
  - pointer := pointer+1, wrapping modulo 2^REG_ADDRESS_WIDTH.
  - ACK always, then WDATA again.
  - reg_response is consumed but not required before the ACK.
- RFETCH: on entry (the ACK scl_rise) pulse reg_request with reg_is_write=0, reg_address=pointer.
  - On reg_response, latch reg_read_data into the shift register.
  - If no response has arrived by the next scl_fall, shift out 8'hFF.
  - Then RDATA.
- RDATA: drive sda_oe = ~bit on each scl_fall for 8 bits, then release SDA for RACK.
- RACK: sample the host bit on scl_rise.
  - ACK(0) → pointer+1 (wrap), RFETCH (fetch issued on that same scl_rise).
  - NACK(1) → IGNORE.
- Request rule: at most one outstanding request. A new reg_request is never asserted in the same cycle as, or before, the reg_response of the prior request.
- Pointer persistence: the pointer persists across STOP/START; a read without a pointer write uses the current pointer.
- Timing: downstream latency ≤ 4 clocks is required (the driver uses 1); covers 400 kHz at 24 MHz.

Decomposition:
- Package i2c_reg_pkg holds the state enum, ACK/NACK constants, the R/W bit index, and the FILTER_CYCLES default.
- Sub-module i2c_line_filter: synchronizer + filter + edge/start/stop detection. It is instantiated once and carries both lines.

Test Plan:
- Write single byte: START, 0x90, 0x03, 0x5A, STOP → ACK on all three bytes; one reg_request with write=1, addr=3, data=0x5A.
- Write burst with wrap: 0x90, 0x02, 0x11, 0x22, 0x33 → writes (2,0x11), (3,0x22), (0,0x33); final pointer=1.
- Read with repeated START: pointer write 0x01, Sr, 0x91, host ACK, host NACK; response data 0xA5 then 0x3C → bus bytes 0xA5, 0x3C; two read requests at addr 1 and 2; SDA released after the NACK.
- Address mismatch: START, 0x92, 0x00 → NACK (SDA never low); no reg_request; next START to 0x90 is accepted.
- Abort: STOP after 4 bits of a data byte → no request, IDLE, sda_oe=0. A glitch on SCL of 2 clocks → no bit sampled.
- Reset mid-read (resetn low for 1 cycle while sda_oe=1) → sda_oe=0 next cycle, pointer=0, state IDLE.
